// File: rtl/casc_rx_buffer.sv
// casc_rx_buffer: first-word-fall-through buffer at the receive end of a
// registered cascade path. Drives the upstream clock-enable (EN) and offers
// the head word downstream on a valid/ready handshake.
// Optional feature macro: CASC_BUF_BYPASS_EN lets a same-cycle pop free
// the slot when full (adds a combinational out_ready -> EN path).
module casc_rx_buffer #(
  parameter int size  = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [size-1:0]            in,
  input  logic                       in_valid,
  output logic                       EN,
  output logic [size-1:0]            out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [size-1:0] mem_q [DEPTH];
  logic [size-1:0] mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic            push, pop;

  // Upstream enable: depends only on occupancy and reset (plus out_ready
  // when the full-occupancy bypass is built in).
  always_comb begin
`ifdef CASC_BUF_BYPASS_EN
    EN = ~rst & ((count_q != FULL) | out_ready);
`else
    EN = ~rst & (count_q != FULL);
`endif
  end

  // Handshake qualifiers and head-of-buffer outputs.
  always_comb begin
    push      = in_valid & EN;
    pop       = out_valid_q & out_ready;
    out       = mem_q[rd_ptr_q];
    out_valid = out_valid_q;
    count     = count_q;
  end

  // Next-state: write at wr_ptr, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
  end

  // State registers; reset clears storage so out reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
